register_bank: RTL and testbench
================================

# register_bank

Register file at the receiving end of the write-back interface. It holds the 2^REG_ADDR_WIDTH general-purpose registers, accepts one write per cycle from the write-back stage, and serves two registered read ports to the decode stage. Same-cycle write-to-read bypass is built in. A pending-write scoreboard raises a stall when decode reads a register that an in-flight instruction has not yet written back.

## Interface
- DATA_WIDTH, 32, register and data width
- REG_ADDR_WIDTH, 5, register address width; NUM_REGS = 2^REG_ADDR_WIDTH
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- reg_wr_en_in  in  1  write strobe from write-back
- reg_wr_addr_in  in  REG_ADDR_WIDTH  write address from write-back
- reg_wr_data_in  in  DATA_WIDTH  write data from write-back
- rd_en_in  in  1  decode requests a read on both ports this cycle
- rd_addr_a_in  in  REG_ADDR_WIDTH  port A read address
- rd_addr_b_in  in  REG_ADDR_WIDTH  port B read address
- pend_set_en_in  in  1  decode issues an instruction that will write pend_set_addr_in
- pend_set_addr_in  in  REG_ADDR_WIDTH  destination of the issued instruction
- rd_data_a_out  out  DATA_WIDTH  registered port A data
- rd_data_b_out  out  DATA_WIDTH  registered port B data
- stall_out  out  1  combinational: the read cannot be served this cycle

## Operation
- Reset clears all registers, all pending bits, rd_data_a_out, and rd_data_b_out to 0.
- Register 0 is hardwired to zero:
  - Writes to it are ignored.
  - pend_set to it is ignored.
  - Reads from it return 0, and it never causes a stall.
- Write: when reg_wr_en_in is high at a clock edge, mem[reg_wr_addr_in] <= reg_wr_data_in.
- Pending bits:
  - A clock edge with pend_set_en_in high sets pending[pend_set_addr_in].
  - A clock edge with reg_wr_en_in high clears pending[reg_wr_addr_in].
  - Set and clear of the same address in the same cycle: set wins. A new producer was issued.
- Hazard per port: hz_x = (addr_x != 0) & pending[addr_x] & ~(reg_wr_en_in & reg_wr_addr_in == addr_x). A write-back arriving in the same cycle resolves the hazard through the bypass.
- stall_out = rd_en_in & (hz_a | hz_b).
- Read capture happens when rd_en_in & ~stall_out:
  - rd_data_x_out <= 0 if addr_x == 0.
  - Otherwise reg_wr_data_in if reg_wr_en_in & reg_wr_addr_in == addr_x (bypass).
  - Otherwise mem[addr_x].
- Outputs hold their value when rd_en_in is low or stall_out is high.
- Both ports may read the same address; both receive the same value.
- pend_set_en_in is accepted even while stall_out is high. Decode is responsible for not issuing during a stall.

## Timing
- Write latency is 1 cycle. A write at edge N is visible from mem after edge N, and visible via bypass during the cycle before edge N.
- Read latency is 1 cycle. Data appears on rd_data_x_out after the edge that samples rd_en_in.
- stall_out is purely combinational from the inputs and the pending bits, with no register stage.
- Asynchronous reset mid-operation clears everything immediately. The first edge after rst deasserts behaves as a normal operating cycle.

## Structure
- Shared package udlx_pkg holds:
  - DATA_WIDTH, REG_ADDR_WIDTH, and NUM_REGS constants.
  - The ZERO_REG address constant.
- Sub-module reg_scoreboard:
  - Contains the NUM_REGS pending bit vector, its set/clear logic, and hazard generation for two query addresses.
  - register_bank holds the storage array, the bypass mux, and the output registers.

## Test plan
- Reset, then read r5/r31 with rd_en_in=1 -> both outputs 0 next cycle; stall_out=0.
- Write r7=0xDEADBEEF; next cycle read A=r7, B=r0 -> A=0xDEADBEEF, B=0.
- Same-cycle write r3=0x12345678 with read A=r3, B=r3 -> both outputs 0x12345678 after that edge.
- pend_set r9, read r9 next cycle -> stall_out=1 and outputs hold. Write-back r9=0xA5A5A5A5 in a later cycle while still reading -> stall_out=0 that cycle, A=0xA5A5A5A5 next.
- Same-cycle pend_set r4 and write-back r4 -> pending[r4] stays 1, and a read of r4 next cycle stalls. Write to r0 with value 0xFFFFFFFF -> reads of r0 still return 0.
- Assert rst mid-stall with r9 pending -> stall_out drops, outputs and registers read 0 after reset.

Source files
------------

// File: rtl/udlx_pkg.sv
// Shared constants for the register file and its write-back / decode neighbours.
package udlx_pkg;

   localparam int DATA_WIDTH     = 32;
   localparam int REG_ADDR_WIDTH = 5;
   localparam int NUM_REGS       = 1 << REG_ADDR_WIDTH;

   localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one bit per register marking an issued producer
// that has not written back yet, plus hazard detection for two read addresses.
module reg_scoreboard
   import udlx_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      set_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] set_addr_i,
   input  logic                      clr_en_i,
   input  logic [REG_ADDR_WIDTH-1:0] clr_addr_i,
   input  logic [REG_ADDR_WIDTH-1:0] qry_a_i,
   input  logic [REG_ADDR_WIDTH-1:0] qry_b_i,
   output logic                      hz_a_o,
   output logic                      hz_b_o
);

   logic [NUM_REGS-1:0] pending_q;
   logic [NUM_REGS-1:0] pending_d;

   // Set is applied after clear so a freshly issued producer wins a collision.
   always_comb begin
      pending_d = pending_q;
      if (clr_en_i) begin
         pending_d[clr_addr_i] = 1'b0;
      end
      if (set_en_i && (set_addr_i != ZERO_REG)) begin
         pending_d[set_addr_i] = 1'b1;
      end
      pending_d[ZERO_REG] = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
      end else begin
         pending_q <= pending_d;
      end
   end

   // A write-back landing this cycle resolves the hazard through the bypass.
   always_comb begin
      hz_a_o = (qry_a_i != ZERO_REG) && pending_q[qry_a_i]
               && !(clr_en_i && (clr_addr_i == qry_a_i));
      hz_b_o = (qry_b_i != ZERO_REG) && pending_q[qry_b_i]
               && !(clr_en_i && (clr_addr_i == qry_b_i));
   end

endmodule

// File: rtl/register_bank.sv
// General-purpose register file: one write-back port, two registered read
// ports with same-cycle bypass, and a stall when decode reads an in-flight register.
module register_bank
   import udlx_pkg::*;
(
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      reg_wr_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in,
   input  logic [DATA_WIDTH-1:0]     reg_wr_data_in,
   input  logic                      rd_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a_in,
   input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b_in,
   input  logic                      pend_set_en_in,
   input  logic [REG_ADDR_WIDTH-1:0] pend_set_addr_in,
   output logic [DATA_WIDTH-1:0]     rd_data_a_out,
   output logic [DATA_WIDTH-1:0]     rd_data_b_out,
   output logic                      stall_out
);

   logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] rd_a_q;
   logic [DATA_WIDTH-1:0] rd_a_d;
   logic [DATA_WIDTH-1:0] rd_b_q;
   logic [DATA_WIDTH-1:0] rd_b_d;
   logic                  hz_a;
   logic                  hz_b;
   logic                  byp_a;
   logic                  byp_b;
   logic                  capture;

   reg_scoreboard u_scoreboard (
      .clk        (clk),
      .rst        (rst),
      .set_en_i   (pend_set_en_in),
      .set_addr_i (pend_set_addr_in),
      .clr_en_i   (reg_wr_en_in),
      .clr_addr_i (reg_wr_addr_in),
      .qry_a_i    (rd_addr_a_in),
      .qry_b_i    (rd_addr_b_in),
      .hz_a_o     (hz_a),
      .hz_b_o     (hz_b)
   );

   assign stall_out = rd_en_in && (hz_a || hz_b);
   assign capture   = rd_en_in && !stall_out;
   assign byp_a     = reg_wr_en_in && (reg_wr_addr_in == rd_addr_a_in);
   assign byp_b     = reg_wr_en_in && (reg_wr_addr_in == rd_addr_b_in);

   always_comb begin
      rd_a_d = rd_a_q;
      rd_b_d = rd_b_q;
      if (capture) begin
         if (rd_addr_a_in == ZERO_REG) begin
            rd_a_d = '0;
         end else if (byp_a) begin
            rd_a_d = reg_wr_data_in;
         end else begin
            rd_a_d = mem_q[rd_addr_a_in];
         end
         if (rd_addr_b_in == ZERO_REG) begin
            rd_b_d = '0;
         end else if (byp_b) begin
            rd_b_d = reg_wr_data_in;
         end else begin
            rd_b_d = mem_q[rd_addr_b_in];
         end
      end
   end

   // r0 is never written, so it stays at its reset value of zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            mem_q[i] <= '0;
         end
      end else if (reg_wr_en_in && (reg_wr_addr_in != ZERO_REG)) begin
         mem_q[reg_wr_addr_in] <= reg_wr_data_in;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_a_q <= '0;
         rd_b_q <= '0;
      end else begin
         rd_a_q <= rd_a_d;
         rd_b_q <= rd_b_d;
      end
   end

   assign rd_data_a_out = rd_a_q;
   assign rd_data_b_out = rd_b_q;

endmodule

// File: tb/tb_register_bank.sv
// Self-checking bench for register_bank: directed scenarios plus a randomized
// run against an array-based reference model of the register file.
module tb_register_bank;
   import udlx_pkg::*;

   logic                      clk;
   logic                      rst;
   logic                      reg_wr_en_in;
   logic [REG_ADDR_WIDTH-1:0] reg_wr_addr_in;
   logic [DATA_WIDTH-1:0]     reg_wr_data_in;
   logic                      rd_en_in;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_a_in;
   logic [REG_ADDR_WIDTH-1:0] rd_addr_b_in;
   logic                      pend_set_en_in;
   logic [REG_ADDR_WIDTH-1:0] pend_set_addr_in;
   logic [DATA_WIDTH-1:0]     rd_data_a_out;
   logic [DATA_WIDTH-1:0]     rd_data_b_out;
   logic                      stall_out;

   int n_checks = 0;
   int n_fail   = 0;

   logic [DATA_WIDTH-1:0] m_mem [NUM_REGS];
   bit                    m_pend [NUM_REGS];
   logic [DATA_WIDTH-1:0] m_a;
   logic [DATA_WIDTH-1:0] m_b;

   register_bank dut (
      .clk              (clk),
      .rst              (rst),
      .reg_wr_en_in     (reg_wr_en_in),
      .reg_wr_addr_in   (reg_wr_addr_in),
      .reg_wr_data_in   (reg_wr_data_in),
      .rd_en_in         (rd_en_in),
      .rd_addr_a_in     (rd_addr_a_in),
      .rd_addr_b_in     (rd_addr_b_in),
      .pend_set_en_in   (pend_set_en_in),
      .pend_set_addr_in (pend_set_addr_in),
      .rd_data_a_out    (rd_data_a_out),
      .rd_data_b_out    (rd_data_b_out),
      .stall_out        (stall_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void model_reset();
      for (int i = 0; i < NUM_REGS; i++) begin
         m_mem[i]  = '0;
         m_pend[i] = 1'b0;
      end
      m_a = '0;
      m_b = '0;
   endfunction

   function automatic bit model_hazard(input int addr);
      if (addr == 0) return 1'b0;
      if (!m_pend[addr]) return 1'b0;
      if (reg_wr_en_in && int'(reg_wr_addr_in) == addr) return 1'b0;
      return 1'b1;
   endfunction

   function automatic bit model_stall();
      return rd_en_in && (model_hazard(int'(rd_addr_a_in)) || model_hazard(int'(rd_addr_b_in)));
   endfunction

   function automatic logic [DATA_WIDTH-1:0] model_value(input int addr);
      if (addr == 0) return '0;
      if (reg_wr_en_in && int'(reg_wr_addr_in) == addr) return reg_wr_data_in;
      return m_mem[addr];
   endfunction

   // Advance the model across one clock edge using the inputs currently driven.
   function automatic void model_edge();
      if (rd_en_in && !model_stall()) begin
         m_a = model_value(int'(rd_addr_a_in));
         m_b = model_value(int'(rd_addr_b_in));
      end
      if (reg_wr_en_in && reg_wr_addr_in != 0) m_mem[reg_wr_addr_in] = reg_wr_data_in;
      if (reg_wr_en_in) m_pend[reg_wr_addr_in] = 1'b0;
      if (pend_set_en_in && pend_set_addr_in != 0) m_pend[pend_set_addr_in] = 1'b1;
   endfunction

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      reg_wr_en_in     = 1'b0;
      reg_wr_addr_in   = '0;
      reg_wr_data_in   = '0;
      rd_en_in         = 1'b0;
      rd_addr_a_in     = '0;
      rd_addr_b_in     = '0;
      pend_set_en_in   = 1'b0;
      pend_set_addr_in = '0;
   endtask

   task automatic test_reset();
      idle_inputs();
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      n_checks++;
      if (rd_data_a_out !== 32'h0 || rd_data_b_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_out: a=%h b=%h expected 0", rd_data_a_out, rd_data_b_out);
      end
      rd_en_in = 1'b1; rd_addr_a_in = 5'd5; rd_addr_b_in = 5'd31;
      #1;
      n_checks++;
      if (stall_out !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_stall: stall=%b expected 0", stall_out);
      end
      tick();
      n_checks++;
      if (rd_data_a_out !== 32'h0 || rd_data_b_out !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_read: a=%h b=%h expected 0", rd_data_a_out, rd_data_b_out);
      end
      idle_inputs();
   endtask

   task automatic test_write_read();
      reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd7; reg_wr_data_in = 32'hDEADBEEF;
      tick();
      idle_inputs();
      rd_en_in = 1'b1; rd_addr_a_in = 5'd7; rd_addr_b_in = 5'd0;
      tick();
      n_checks++;
      if (rd_data_a_out !== 32'hDEADBEEF || rd_data_b_out !== 32'h0) begin
         n_fail++;
         $display("FAIL write_read: a=%h b=%h expected deadbeef/0", rd_data_a_out, rd_data_b_out);
      end
      idle_inputs();
   endtask

   task automatic test_bypass();
      reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd3; reg_wr_data_in = 32'h12345678;
      rd_en_in = 1'b1; rd_addr_a_in = 5'd3; rd_addr_b_in = 5'd3;
      tick();
      n_checks++;
      if (rd_data_a_out !== 32'h12345678 || rd_data_b_out !== 32'h12345678) begin
         n_fail++;
         $display("FAIL bypass: a=%h b=%h expected 12345678", rd_data_a_out, rd_data_b_out);
      end
      idle_inputs();
   endtask

   task automatic test_stall();
      logic [DATA_WIDTH-1:0] held_a;
      logic [DATA_WIDTH-1:0] held_b;
      pend_set_en_in = 1'b1; pend_set_addr_in = 5'd9;
      tick();
      idle_inputs();
      held_a = rd_data_a_out;
      held_b = rd_data_b_out;
      rd_en_in = 1'b1; rd_addr_a_in = 5'd9; rd_addr_b_in = 5'd7;
      #1;
      n_checks++;
      if (stall_out !== 1'b1) begin
         n_fail++;
         $display("FAIL stall_raise: stall=%b expected 1", stall_out);
      end
      tick();
      n_checks++;
      if (rd_data_a_out !== held_a || rd_data_b_out !== held_b) begin
         n_fail++;
         $display("FAIL stall_hold: a=%h b=%h expected %h/%h", rd_data_a_out, rd_data_b_out, held_a, held_b);
      end
      reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd9; reg_wr_data_in = 32'hA5A5A5A5;
      #1;
      n_checks++;
      if (stall_out !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_resolve: stall=%b expected 0", stall_out);
      end
      tick();
      n_checks++;
      if (rd_data_a_out !== 32'hA5A5A5A5 || rd_data_b_out !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL stall_wb_data: a=%h b=%h expected a5a5a5a5/deadbeef", rd_data_a_out, rd_data_b_out);
      end
      idle_inputs();
   endtask

   task automatic test_set_clear_collision();
      pend_set_en_in = 1'b1; pend_set_addr_in = 5'd4;
      reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd4; reg_wr_data_in = 32'h0BADF00D;
      tick();
      idle_inputs();
      rd_en_in = 1'b1; rd_addr_a_in = 5'd0; rd_addr_b_in = 5'd4;
      #1;
      n_checks++;
      if (stall_out !== 1'b1) begin
         n_fail++;
         $display("FAIL collision_stall: stall=%b expected 1", stall_out);
      end
      reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd4; reg_wr_data_in = 32'h44444444;
      tick();
      n_checks++;
      if (rd_data_b_out !== 32'h44444444) begin
         n_fail++;
         $display("FAIL collision_clear: b=%h expected 44444444", rd_data_b_out);
      end
      idle_inputs();
   endtask

   task automatic test_zero_reg();
      reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd0; reg_wr_data_in = 32'hFFFFFFFF;
      pend_set_en_in = 1'b1; pend_set_addr_in = 5'd0;
      tick();
      idle_inputs();
      rd_en_in = 1'b1; rd_addr_a_in = 5'd0; rd_addr_b_in = 5'd0;
      #1;
      n_checks++;
      if (stall_out !== 1'b0) begin
         n_fail++;
         $display("FAIL zero_stall: stall=%b expected 0", stall_out);
      end
      tick();
      n_checks++;
      if (rd_data_a_out !== 32'h0 || rd_data_b_out !== 32'h0) begin
         n_fail++;
         $display("FAIL zero_read: a=%h b=%h expected 0", rd_data_a_out, rd_data_b_out);
      end
      // bypass must not leak a write to r0 either
      reg_wr_en_in = 1'b1; reg_wr_addr_in = 5'd0; reg_wr_data_in = 32'hFFFFFFFF;
      tick();
      n_checks++;
      if (rd_data_a_out !== 32'h0 || rd_data_b_out !== 32'h0) begin
         n_fail++;
         $display("FAIL zero_bypass: a=%h b=%h expected 0", rd_data_a_out, rd_data_b_out);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid_stall();
      pend_set_en_in = 1'b1; pend_set_addr_in = 5'd9;
      tick();
      idle_inputs();
      rd_en_in = 1'b1; rd_addr_a_in = 5'd9; rd_addr_b_in = 5'd3;
      #1;
      n_checks++;
      if (stall_out !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_prestall: stall=%b expected 1", stall_out);
      end
      #2;
      rst = 1'b1;
      model_reset();
      #1;
      n_checks++;
      if (stall_out !== 1'b0 || rd_data_a_out !== 32'h0 || rd_data_b_out !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_clear: stall=%b a=%h b=%h expected 0/0/0", stall_out, rd_data_a_out, rd_data_b_out);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      rd_en_in = 1'b1; rd_addr_a_in = 5'd7; rd_addr_b_in = 5'd3;
      tick();
      n_checks++;
      if (rd_data_a_out !== 32'h0 || rd_data_b_out !== 32'h0) begin
         n_fail++;
         $display("FAIL midrst_regs: a=%h b=%h expected 0", rd_data_a_out, rd_data_b_out);
      end
      idle_inputs();
   endtask

   task automatic test_random();
      for (int cyc = 0; cyc < 400; cyc++) begin
         reg_wr_en_in     = ($urandom_range(0, 99) < 45);
         reg_wr_addr_in   = REG_ADDR_WIDTH'($urandom_range(0, 7));
         reg_wr_data_in   = $urandom;
         rd_en_in         = ($urandom_range(0, 99) < 70);
         rd_addr_a_in     = REG_ADDR_WIDTH'($urandom_range(0, 7));
         rd_addr_b_in     = ($urandom_range(0, 9) == 0) ? REG_ADDR_WIDTH'($urandom_range(0, 31))
                                                        : REG_ADDR_WIDTH'($urandom_range(0, 7));
         pend_set_en_in   = ($urandom_range(0, 99) < 25);
         pend_set_addr_in = REG_ADDR_WIDTH'($urandom_range(0, 7));
         #1;
         n_checks++;
         if (stall_out !== model_stall()) begin
            n_fail++;
            $display("FAIL rand_stall cyc=%0d: stall=%b expected %b", cyc, stall_out, model_stall());
         end
         tick();
         n_checks++;
         if (rd_data_a_out !== m_a || rd_data_b_out !== m_b) begin
            n_fail++;
            $display("FAIL rand_data cyc=%0d: a=%h b=%h expected %h/%h", cyc, rd_data_a_out, rd_data_b_out, m_a, m_b);
         end
      end
      idle_inputs();
   endtask

   initial begin
      rst = 1'b1;
      idle_inputs();
      test_reset();
      test_write_read();
      test_bypass();
      test_stall();
      test_set_clear_collision();
      test_zero_reg();
      test_reset_mid_stall();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
